scmp_step_ctrl: RTL and testbench

//  Board-side control input for the SC/MP demo top.

---
 rtl/scmp_step_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_scmp_step_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scmp_step_ctrl.sv
// -----------------------------------------------------------------------------
// scmp_step_ctrl
//   Board-side control for the SC/MP demo top. Conditions two active-low
//   push-buttons (two-flop synchroniser, debounce, press detect) and generates
//   the CPU clock either free-running from a divider or one full period per
//   step press. Reports the run/stop mode and a count of CPU clock rises.
//
// Ports
//   clk_50m  in   1   system clock, 50 MHz
//   rst_n    in   1   asynchronous active-low reset
//   btn_n    in   2   raw buttons, active low, asynchronous: [0]=step, [1]=run/stop
//   cpu_clk  out  1   registered CPU clock
//   run      out  1   high while in RUN (including while a stop is pending)
//   cyc_cnt  out  16  number of cpu_clk rising edges, wraps
// -----------------------------------------------------------------------------
module scmp_step_ctrl #(
    parameter int DIV_SIZE     = 26,
    parameter int DEB_CYCLES   = 1000000,
    parameter int DEB_W        = 20,
    parameter int PULSE_CYCLES = 2500000,
    parameter bit START_RUN    = 1'b1
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [1:0]  btn_n,
    output logic        cpu_clk,
    output logic        run,
    output logic [15:0] cyc_cnt
);

    localparam int PH_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_STOP, S_STEP_HI, S_STEP_LO} state_t;
    localparam state_t RESET_STATE = START_RUN ? S_RUN : S_STOP;

    // ------------------------------------------------------------------
    // Input conditioning: synchroniser stages, debounce, press detect
    // ------------------------------------------------------------------
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       samp;
    logic [1:0]       deb_lvl;
    logic [1:0]       deb_rise;
    logic [1:0]       press;
    logic [DEB_W-1:0] deb_cnt [2];
    logic             press_step;
    logic             press_mode;

    assign samp       = ~sync_p1;
    assign press_step = press[0];
    assign press_mode = press[1];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
        end
    end

    // A debounced level rises on the last of DEB_CYCLES differing samples.
    always_comb begin
        deb_rise = '0;
        for (int b = 0; b < 2; b++) begin
            deb_rise[b] = samp[b] & ~deb_lvl[b] & (deb_cnt[b] == DEB_LAST);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= '0;
            press   <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            press <= deb_rise;
            for (int b = 0; b < 2; b++) begin
                if (samp[b] == deb_lvl[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    deb_lvl[b] <= samp[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Clock-mode FSM
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [DIV_SIZE-1:0] div;
    logic [DIV_SIZE-1:0] div_nxt;
    logic [PH_W-1:0]     ph;
    logic [PH_W-1:0]     ph_nxt;
    logic                stop_req;
    logic                stop_req_nxt;
    logic                cpu_clk_nxt;
    logic                clk_rise;

    assign clk_rise = cpu_clk_nxt & ~cpu_clk;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            div      <= '1;
            ph       <= '0;
            stop_req <= 1'b0;
            cpu_clk  <= 1'b0;
            cyc_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            ph       <= ph_nxt;
            stop_req <= stop_req_nxt;
            cpu_clk  <= cpu_clk_nxt;
            cyc_cnt  <= cyc_cnt + {15'd0, clk_rise};
        end
    end

    always_comb begin
        state_nxt    = state;
        div_nxt      = div;
        ph_nxt       = ph;
        stop_req_nxt = stop_req;
        case (state)
            S_RUN: begin
                div_nxt = div - 1'b1;
                if (press_mode) begin
                    stop_req_nxt = 1'b1;
                end
                // Stopping only at divider zero ends a complete low phase.
                if (stop_req && (div == '0)) begin
                    state_nxt    = S_STOP;
                    stop_req_nxt = 1'b0;
                end
            end
            S_STOP: begin
                // Mode wins over a simultaneous step; reload gives a full high phase.
                if (press_mode) begin
                    state_nxt = S_RUN;
                    div_nxt   = '1;
                end else if (press_step) begin
                    state_nxt = S_STEP_HI;
                    ph_nxt    = '0;
                end
            end
            S_STEP_HI: begin
                if (ph == PH_LAST) begin
                    state_nxt = S_STEP_LO;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph + 1'b1;
                end
            end
            S_STEP_LO: begin
                if (ph == PH_LAST) begin
                    state_nxt = S_STOP;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph + 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        run         = (state == S_RUN);
        cpu_clk_nxt = 1'b0;
        case (state)
            S_RUN:     cpu_clk_nxt = div[DIV_SIZE-1];
            S_STEP_HI: cpu_clk_nxt = 1'b1;
            default:   cpu_clk_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_scmp_step_ctrl.sv
module tb_scmp_step_ctrl;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [1:0]  btn_n;
    logic        cpu_clk;
    logic        run;
    logic [15:0] cyc_cnt;

    int n_cmp = 0;
    int n_err = 0;

    scmp_step_ctrl #(
        .DIV_SIZE    (4),
        .DEB_CYCLES  (4),
        .DEB_W       (20),
        .PULSE_CYCLES(3),
        .START_RUN   (1'b1)
    ) dut (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
        .cpu_clk(cpu_clk),
        .run    (run),
        .cyc_cnt(cyc_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Number of consecutive samples (starting now) with cpu_clk at lvl.
    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (cpu_clk === lvl && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int lo;

        // 1: reset values, free-run timing and rise count
        btn_n = 2'b11;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        chk("rst_run", run, 1);
        rst_n = 1'b1;
        tick();
        chk("first_rise_clk", cpu_clk, 1);
        chk("first_rise_cnt", cyc_cnt, 1);
        count_level(1'b1, n);
        chk("free_high_len", n, 8);
        count_level(1'b0, n);
        chk("free_low_len", n, 8);
        chk("second_rise_cnt", cyc_cnt, 2);
        count_level(1'b1, n);
        count_level(1'b0, n);
        chk("third_rise_cnt", cyc_cnt, 3);
        chk("third_rise_clk", cpu_clk, 1);

        // 2: bouncing mode button, then a clean hold -> one stop at divider zero
        for (int i = 0; i < 8; i++) begin
            btn_n[1] = ((i / 2) % 2 == 1);
            tick();
        end
        chk("run_during_bounce", run, 1);
        btn_n[1] = 1'b0;
        n  = 0;
        lo = 0;
        while (run !== 1'b0 && n < 100) begin
            tick();
            n++;
            lo = (cpu_clk === 1'b0) ? lo + 1 : 0;
        end
        chk("stop_latency", n, 23);
        chk("stop_run", run, 0);
        chk("stop_full_low", lo, 8);
        chk("stop_cyc_cnt", cyc_cnt, 4);
        btn_n[1] = 1'b1;
        repeat (20) tick();
        chk("stopped_run", run, 0);
        chk("stopped_clk", cpu_clk, 0);
        chk("stopped_cyc_cnt", cyc_cnt, 4);

        // 3: single step from STOP
        btn_n[0] = 1'b0;
        n = 0;
        while (cpu_clk !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("step_rise", cpu_clk, 1);
        chk("step_cyc_cnt", cyc_cnt, 5);
        chk("step_run", run, 0);
        count_level(1'b1, n);
        chk("step_high_len", n, 3);
        btn_n[0] = 1'b1;
        repeat (20) tick();
        chk("step_after_clk", cpu_clk, 0);
        chk("step_after_cnt", cyc_cnt, 5);
        chk("step_after_run", run, 0);

        // 4: a press arriving during STEP_HI is discarded
        btn_n[0] = 1'b0;
        tick();
        tick();
        btn_n[1] = 1'b0;
        n = 0;
        while (cpu_clk !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("step2_rise", cpu_clk, 1);
        chk("step2_cyc_cnt", cyc_cnt, 6);
        count_level(1'b1, n);
        chk("step2_high_len", n, 3);
        chk("step2_run", run, 0);
        btn_n = 2'b11;
        repeat (20) tick();
        chk("step2_after_run", run, 0);
        chk("step2_after_clk", cpu_clk, 0);
        chk("step2_after_cnt", cyc_cnt, 6);

        // 5: simultaneous mode and step presses in STOP -> RUN, no step
        btn_n = 2'b00;
        n = 0;
        while (run !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("both_run", run, 1);
        chk("both_entry_clk", cpu_clk, 0);
        tick();
        chk("both_rise_clk", cpu_clk, 1);
        chk("both_rise_cnt", cyc_cnt, 7);
        count_level(1'b1, n);
        chk("both_high_len", n, 8);
        btn_n = 2'b11;
        count_level(1'b0, n);
        chk("both_low_len", n, 8);
        chk("both_next_cnt", cyc_cnt, 8);

        // 6: reset asserted in the middle of a step
        btn_n[1] = 1'b0;
        n = 0;
        while (run !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("stop2_run", run, 0);
        btn_n[1] = 1'b1;
        repeat (20) tick();
        chk("stop2_cyc_cnt", cyc_cnt, 8);
        btn_n[0] = 1'b0;
        n = 0;
        while (cpu_clk !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("step3_rise", cpu_clk, 1);
        chk("step3_cyc_cnt", cyc_cnt, 9);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk", cpu_clk, 0);
        chk("async_rst_cnt", cyc_cnt, 0);
        chk("async_rst_run", run, 1);
        btn_n = 2'b11;
        tick();
        tick();
        chk("held_rst_clk", cpu_clk, 0);
        rst_n = 1'b1;
        tick();
        chk("resume_clk", cpu_clk, 1);
        chk("resume_cnt", cyc_cnt, 1);
        chk("resume_run", run, 1);
        count_level(1'b1, n);
        chk("resume_high_len", n, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
